// File: rtl/mlp_train_seq.sv
// Training-loop sequencer: walks samples through the forward pass, forms the error, strobes learning.
// Optional MLP_TRAIN_DEADZONE_EN: suppress learn when the error is small and the sample was not a miss.
module mlp_train_seq #(
   parameter int W           = 8,
   parameter int NUM_SAMPLES = 16,
   parameter int MAX_EPOCH   = 255,
   parameter int TGT         = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   output logic [7:0]          smp_addr,
   input  logic [15:0]         smp_x,
   input  logic                smp_label,
   output logic [15:0]         x_out,
   output logic                fwd_start,
   input  logic                fwd_done,
   input  logic signed [W-1:0] fwd_y,
   output logic                learn,
   output logic signed [W-1:0] err,
   output logic                busy,
   output logic                done,
   output logic                converged,
   output logic [7:0]          epoch_cnt,
   output logic [7:0]          miss_cnt
);

   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, WAIT, UPDATE, NEXT, FIN
   } state_t;

   localparam logic signed [W:0]   TGT_S   = (W+1)'(TGT);
   localparam logic signed [W-1:0] ERR_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] ERR_MIN = {1'b1, {(W-1){1'b0}}};

   state_t              r_state, r_nxt;
   logic [7:0]          r_idx;
   logic [7:0]          r_epoch;
   logic [7:0]          r_miss;
   logic                r_conv;
   logic [15:0]         r_x;
   logic                r_label;
   logic signed [W-1:0] r_err;

   logic signed [W:0]   w_tgt;
   logic signed [W:0]   w_diff;
   logic signed [W-1:0] w_err_sat;
   logic                w_pred;
   logic                w_miss;
   logic                w_last;
   logic [7:0]          w_epoch_nx;
   logic                w_abort;
   logic                w_learn_ok;

   assign w_tgt      = r_label ? TGT_S : -TGT_S;
   assign w_diff     = w_tgt - $signed({fwd_y[W-1], fwd_y});
   // W+1-bit result overflows the W-bit range when its top two bits differ
   assign w_err_sat  = (w_diff[W] != w_diff[W-1]) ?
                       (w_diff[W] ? ERR_MIN : ERR_MAX) : w_diff[W-1:0];
   assign w_pred     = !fwd_y[W-1] && (fwd_y != '0);
   assign w_miss     = w_pred != r_label;
   assign w_last     = r_idx == 8'(NUM_SAMPLES - 1);
   assign w_epoch_nx = r_epoch + 8'd1;
   assign w_abort    = abort && (r_state != IDLE);

`ifdef MLP_TRAIN_DEADZONE_EN
   logic          r_smp_miss;
   logic [W:0]    w_err_x;
   logic [W:0]    w_abs;
   assign w_err_x    = {r_err[W-1], r_err};
   assign w_abs      = r_err[W-1] ? (~w_err_x + 1'b1) : w_err_x;
   assign w_learn_ok = r_smp_miss || (w_abs >= (W+1)'(TGT / 4));
`else
   assign w_learn_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= r_nxt;
   end

   always_comb begin
      r_nxt = r_state;
      case (r_state)
         IDLE:   if (start) r_nxt = FETCH;
         FETCH:  r_nxt = LOAD;
         LOAD:   r_nxt = WAIT;
         WAIT:   if (fwd_done) r_nxt = UPDATE;
         UPDATE: r_nxt = NEXT;
         NEXT: begin
            if (!w_last)
               r_nxt = FETCH;
            else if (r_miss == 8'd0 || w_epoch_nx == 8'(MAX_EPOCH))
               r_nxt = FIN;
            else
               r_nxt = FETCH;
         end
         FIN:    r_nxt = IDLE;
         default: r_nxt = IDLE;
      endcase
      if (w_abort) r_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx   <= '0;
         r_epoch <= '0;
         r_miss  <= '0;
         r_conv  <= 1'b0;
         r_x     <= '0;
         r_label <= 1'b0;
         r_err   <= '0;
`ifdef MLP_TRAIN_DEADZONE_EN
         r_smp_miss <= 1'b0;
`endif
      end else if (w_abort) begin
         r_conv <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_idx   <= '0;
               r_epoch <= '0;
               r_miss  <= '0;
               r_conv  <= 1'b0;
            end
            LOAD: begin
               r_x     <= smp_x;
               r_label <= smp_label;
            end
            WAIT: if (fwd_done) begin
               r_err <= w_err_sat;
               if (w_miss && r_miss != 8'hFF) r_miss <= r_miss + 8'd1;
`ifdef MLP_TRAIN_DEADZONE_EN
               r_smp_miss <= w_miss;
`endif
            end
            NEXT: begin
               if (!w_last) begin
                  r_idx <= r_idx + 8'd1;
               end else begin
                  r_idx   <= '0;
                  r_epoch <= w_epoch_nx;
                  // the final epoch's miss count stays visible in FIN
                  if (r_miss == 8'd0)
                     r_conv <= 1'b1;
                  else if (w_epoch_nx != 8'(MAX_EPOCH))
                     r_miss <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign smp_addr  = r_idx;
   assign x_out     = r_x;
   assign err       = r_err;
   assign fwd_start = (r_state == LOAD) && !abort;
   assign learn     = (r_state == UPDATE) && !abort && w_learn_ok;
   assign done      = (r_state == FIN) && !abort;
   assign busy      = r_state != IDLE;
   assign converged = r_conv;
   assign epoch_cnt = r_epoch;
   assign miss_cnt  = r_miss;

endmodule

// File: tb/tb_mlp_train_seq.sv
// Scoreboard bench for mlp_train_seq: directed runs, expected learn/done events queued up front.
module tb_mlp_train_seq;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [7:0]        smp_addr;
   logic [15:0]       smp_x = '0;
   logic              smp_label = 1'b0;
   logic [15:0]       x_out;
   logic              fwd_start;
   logic              fwd_done = 1'b0;
   logic signed [7:0] fwd_y = '0;
   logic              learn;
   logic signed [7:0] err;
   logic              busy, done, converged;
   logic [7:0]        epoch_cnt, miss_cnt;

   mlp_train_seq #(.W(8), .NUM_SAMPLES(4), .MAX_EPOCH(3), .TGT(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .smp_addr(smp_addr), .smp_x(smp_x), .smp_label(smp_label),
      .x_out(x_out), .fwd_start(fwd_start), .fwd_done(fwd_done),
      .fwd_y(fwd_y), .learn(learn), .err(err), .busy(busy),
      .done(done), .converged(converged), .epoch_cnt(epoch_cnt),
      .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int conv;
      int ep;
      int miss;
   } done_t;

   int    checks = 0;
   int    errors = 0;
   int    exp_err_q[$];
   done_t exp_done_q[$];
   int    done_seen = 0;
   int    fcnt = 0;

   logic              mem_lab[4];
   logic signed [7:0] ytab[4];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   // sample memory and forward-pass model; x_out low bits carry the index
   always @(negedge clk) begin
      smp_x     = 16'hA000 + 16'(smp_addr[1:0]);
      smp_label = mem_lab[smp_addr[1:0]];
      fwd_done  = 1'b0;
      if (!rst_n) fcnt = 0;
      else if (fwd_start) fcnt = 2;
      else if (fcnt > 0) begin
         fcnt--;
         if (fcnt == 0) begin
            fwd_done = 1'b1;
            fwd_y    = ytab[x_out[1:0]];
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && learn) begin
         if (exp_err_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL learn_unexpected err %0d", err);
         end else begin
            chk("learn_err", int'(err), exp_err_q.pop_front());
         end
      end
      if (rst_n && done) begin
         done_seen++;
         if (exp_done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected epoch %0d", epoch_cnt);
         end else begin
            done_t d;
            d = exp_done_q.pop_front();
            chk("done_converged", int'(converged), d.conv);
            chk("done_epoch", int'(epoch_cnt), d.ep);
            chk("done_miss", int'(miss_cnt), d.miss);
         end
      end
   end

   task automatic set_tab(input logic l0, l1, l2, l3,
                          input logic signed [7:0] y0, y1, y2, y3);
      mem_lab[0] = l0; mem_lab[1] = l1; mem_lab[2] = l2; mem_lab[3] = l3;
      ytab[0] = y0; ytab[1] = y1; ytab[2] = y2; ytab[3] = y3;
   endtask

   task automatic push_errs(input int n, input int e0, input int e1);
      for (int i = 0; i < n; i++) exp_err_q.push_back((i % 2 == 0) ? e0 : e1);
   endtask

   task automatic push_done(input int c, input int e, input int m);
      done_t d;
      d.conv = c; d.ep = e; d.miss = m;
      exp_done_q.push_back(d);
   endtask

   task automatic start_run();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int lim);
      int base;
      bit seen;
      base = done_seen;
      seen = 0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (done_seen != base) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s timeout no done after %0d cycles", nm, lim);
      end
      @(negedge clk);
      chk({nm, "_idle_busy"}, int'(busy), 0);
   endtask

   initial begin
      set_tab(1, 1, 1, 1, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_learn", int'(learn), 0);
      chk("rst_fwd_start", int'(fwd_start), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_smp_addr", int'(smp_addr), 0);
      chk("rst_x_out", int'(x_out), 0);
      chk("rst_epoch", int'(epoch_cnt), 0);
      chk("rst_miss", int'(miss_cnt), 0);
      chk("rst_conv", int'(converged), 0);
      rst_n = 1'b1;

      // converging run: err = +-32 - (+-40) = -+8
      set_tab(1, 0, 1, 0, 40, -40, 40, -40);
      push_errs(4, -8, 8);
      push_done(1, 1, 0);
      start_run();
      wait_done("conv", 200);
      chk("conv_hold_epoch", int'(epoch_cnt), 1);

      // never converges: y=0 predicts label 0, every sample a miss
      set_tab(1, 1, 1, 1, 0, 0, 0, 0);
      push_errs(12, 32, 32);
      push_done(0, 3, 4);
      start_run();
      wait_done("maxep", 400);
      chk("maxep_hold_miss", int'(miss_cnt), 4);

      // saturation: -32-127 -> -128, 32+128 -> 127
      set_tab(0, 1, 0, 1, 127, -128, 127, -128);
      push_errs(12, -128, 127);
      push_done(0, 3, 4);
      start_run();
      wait_done("sat", 400);

      // abort in WAIT of sample 2
      set_tab(1, 1, 1, 1, 40, 40, 40, 40);
      push_errs(2, -8, -8);
      start_run();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fwd_start && smp_addr == 8'd2) break;
      end
      @(negedge clk);
      chk("abort_wait_busy", int'(busy), 1);
      chk("abort_wait_addr", int'(smp_addr), 2);
      abort = 1'b1;
      #1;
      chk("abort_no_learn", int'(learn), 0);
      chk("abort_no_done", int'(done), 0);
      @(negedge clk) abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_conv", int'(converged), 0);
      repeat (4) @(negedge clk);
      chk("abort_busy_later", int'(busy), 0);
      chk("abort_learns_left", exp_err_q.size(), 0);
      push_errs(4, -8, -8);
      push_done(1, 1, 0);
      start_run();
      chk("restart_addr", int'(smp_addr), 0);
      chk("restart_epoch", int'(epoch_cnt), 0);
      chk("restart_busy", int'(busy), 1);
      wait_done("restart", 200);

`ifdef MLP_TRAIN_DEADZONE_EN
      // err 2 sits inside the dead zone, err 12 does not
      set_tab(1, 1, 1, 1, 30, 20, 30, 20);
      push_errs(2, 12, 12);
      push_done(1, 1, 0);
      start_run();
      wait_done("dz", 200);
`endif

      // async reset in the middle of UPDATE
      set_tab(1, 1, 1, 1, 40, 40, 40, 40);
      push_errs(1, -8, -8);
      start_run();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (learn) break;
      end
      chk("mid_learn_seen", int'(learn), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_learn", int'(learn), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_err", int'(err), 0);
      chk("arst_x_out", int'(x_out), 0);
      @(negedge clk) begin
         rst_n = 1'b1;
         start = 1'b1;
      end
      @(negedge clk) start = 1'b0;
      chk("first_start_busy", int'(busy), 1);
      chk("first_start_addr", int'(smp_addr), 0);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("final_abort_busy", int'(busy), 0);

      chk("learn_queue_empty", exp_err_q.size(), 0);
      chk("done_queue_empty", exp_done_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
